// File: rtl/backprop_sequencer.sv
// backprop_sequencer: walks the cost phase, then every dense layer from the output
// side down to layer 0, one weight row per step, holding each step until step_ready.
module backprop_sequencer #(
  parameter int size        = 3,
  parameter int layer_count = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        step_ready,
  output logic        busy,
  output logic        done,
  output logic        is_update,
  output logic [31:0] w_layer_index,
  output logic [31:0] w_row_index,
  output logic        is_cost_layer,
  output logic        backprop_cost
);

  localparam logic [31:0] LAST_R = 32'(size - 1);
  localparam logic [31:0] LAST_L = 32'(layer_count - 1);

  typedef enum logic [1:0] {
    IDLE,
    COST,
    DENSE,
    DONE
  } state_t;

  state_t      r_state;
  logic        r_upd;
  logic        r_done;
  logic        r_cost;
  logic [31:0] r_layer;
  logic [31:0] r_row;

  // Step counters double as the registered step outputs; they read 0 when idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_upd   <= 1'b0;
      r_done  <= 1'b0;
      r_cost  <= 1'b0;
      r_layer <= '0;
      r_row   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= COST;
            r_upd   <= 1'b1;
            r_cost  <= 1'b1;
            r_layer <= LAST_L;
            r_row   <= '0;
          end
        end
        COST, DENSE: begin
          if (abort) begin
            r_state <= IDLE;
            r_upd   <= 1'b0;
            r_cost  <= 1'b0;
            r_layer <= '0;
            r_row   <= '0;
          end else if (step_ready) begin
            if (r_row != LAST_R) begin
              r_row <= r_row + 32'd1;
            end else if (r_state == COST) begin
              r_state <= DENSE;
              r_cost  <= 1'b0;
              r_layer <= LAST_L;
              r_row   <= '0;
            end else if (r_layer != 32'd0) begin
              r_layer <= r_layer - 32'd1;
              r_row   <= '0;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_upd   <= 1'b0;
              r_layer <= '0;
              r_row   <= '0;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy          = r_upd;
  assign is_update     = r_upd;
  assign done          = r_done;
  assign is_cost_layer = r_cost;
  assign backprop_cost = r_cost;
  assign w_layer_index = r_layer;
  assign w_row_index   = r_row;

endmodule

// File: tb/tb_backprop_sequencer.sv
// tb_backprop_sequencer: table-driven vectors through a scoreboard queue, plus
// hand-written sequences for the degenerate sizes and a toggling step_ready.
module tb_backprop_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        step_ready = 1'b0;
  logic        busy, done, is_update, is_cost_layer, backprop_cost;
  logic [31:0] w_layer_index, w_row_index;

  logic        d_start = 1'b0;
  logic        d_abort = 1'b0;
  logic        d_sr = 1'b1;
  logic        d_busy, d_done, d_upd, d_cost, d_bc;
  logic [31:0] d_layer, d_row;

  backprop_sequencer #(.size(3), .layer_count(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .step_ready(step_ready), .busy(busy), .done(done),
    .is_update(is_update), .w_layer_index(w_layer_index),
    .w_row_index(w_row_index), .is_cost_layer(is_cost_layer),
    .backprop_cost(backprop_cost)
  );

  backprop_sequencer #(.size(1), .layer_count(1)) u_deg (
    .clk(clk), .reset_n(reset_n), .start(d_start), .abort(d_abort),
    .step_ready(d_sr), .busy(d_busy), .done(d_done),
    .is_update(d_upd), .w_layer_index(d_layer),
    .w_row_index(d_row), .is_cost_layer(d_cost),
    .backprop_cost(d_bc)
  );

  typedef struct {
    logic        st;
    logic        ab;
    logic        sr;
    logic        rn;
    logic [68:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [68:0] sb[$];
  int          nchk = 0;
  int          npass = 0;

  // {busy, done, is_update, is_cost_layer, backprop_cost, layer, row}
  function automatic logic [68:0] ev(logic u, logic d, logic c, int l, int r);
    return {u, d, u, c, c, 32'(l), 32'(r)};
  endfunction

  function automatic logic [68:0] pk(logic b, logic d, logic u, logic c,
                                     logic bc, logic [31:0] l, logic [31:0] r);
    return {b, d, u, c, bc, l, r};
  endfunction

  function automatic void add(logic st, logic ab, logic sr, logic rn,
                              logic [68:0] e);
    vec_t v;
    v.st = st; v.ab = ab; v.sr = sr; v.rn = rn; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [68:0] got, logic [68:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  logic [68:0] IDL, DNE;
  logic [68:0] e;
  int          sl[9];
  int          srw[9];
  logic        sc[9];
  int          idx;

  initial begin
    IDL = ev(0, 0, 0, 0, 0);
    DNE = ev(0, 1, 0, 0, 0);

    // full pass, no stalls
    add(0, 0, 0, 0, IDL);
    add(0, 0, 1, 1, IDL);
    add(1, 0, 1, 1, ev(1, 0, 1, 1, 0));
    add(0, 0, 1, 1, ev(1, 0, 1, 1, 1));
    add(0, 0, 1, 1, ev(1, 0, 1, 1, 2));
    add(0, 0, 1, 1, ev(1, 0, 0, 1, 0));
    add(0, 0, 1, 1, ev(1, 0, 0, 1, 1));
    add(0, 0, 1, 1, ev(1, 0, 0, 1, 2));
    add(0, 0, 1, 1, ev(1, 0, 0, 0, 0));
    add(0, 0, 1, 1, ev(1, 0, 0, 0, 1));
    add(0, 0, 1, 1, ev(1, 0, 0, 0, 2));
    add(0, 0, 1, 1, DNE);
    add(0, 0, 1, 1, IDL);
    // stall in cycles 5-7, with stray start pulses (one in DONE)
    add(1, 0, 1, 1, ev(1, 0, 1, 1, 0));
    add(0, 0, 1, 1, ev(1, 0, 1, 1, 1));
    add(0, 0, 1, 1, ev(1, 0, 1, 1, 2));
    add(1, 0, 1, 1, ev(1, 0, 0, 1, 0));
    add(0, 0, 1, 1, ev(1, 0, 0, 1, 1));
    add(0, 0, 0, 1, ev(1, 0, 0, 1, 1));
    add(1, 0, 0, 1, ev(1, 0, 0, 1, 1));
    add(0, 0, 0, 1, ev(1, 0, 0, 1, 1));
    add(0, 0, 1, 1, ev(1, 0, 0, 1, 2));
    add(0, 0, 1, 1, ev(1, 0, 0, 0, 0));
    add(0, 0, 1, 1, ev(1, 0, 0, 0, 1));
    add(0, 0, 1, 1, ev(1, 0, 0, 0, 2));
    add(0, 0, 1, 1, DNE);
    add(1, 0, 1, 1, IDL);
    add(0, 0, 1, 1, IDL);
    // abort at cost row 2, abort in idle, start beats abort
    add(1, 0, 1, 1, ev(1, 0, 1, 1, 0));
    add(0, 0, 1, 1, ev(1, 0, 1, 1, 1));
    add(0, 0, 1, 1, ev(1, 0, 1, 1, 2));
    add(0, 1, 1, 1, IDL);
    add(0, 0, 1, 1, IDL);
    add(0, 1, 1, 1, IDL);
    add(1, 1, 1, 1, ev(1, 0, 1, 1, 0));
    add(0, 0, 0, 1, ev(1, 0, 1, 1, 0));
    add(0, 1, 0, 1, IDL);
    // reset during the dense phase
    add(1, 0, 1, 1, ev(1, 0, 1, 1, 0));
    add(0, 0, 1, 1, ev(1, 0, 1, 1, 1));
    add(0, 0, 1, 1, ev(1, 0, 1, 1, 2));
    add(0, 0, 1, 1, ev(1, 0, 0, 1, 0));
    add(0, 0, 1, 1, ev(1, 0, 0, 1, 1));
    add(0, 0, 1, 0, IDL);
    add(0, 0, 1, 1, IDL);
    add(0, 0, 1, 1, IDL);

    foreach (vecs[i]) begin
      @(negedge clk);
      start      = vecs[i].st;
      abort      = vecs[i].ab;
      step_ready = vecs[i].sr;
      reset_n    = vecs[i].rn;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d", i),
          pk(busy, done, is_update, is_cost_layer, backprop_cost,
             w_layer_index, w_row_index), e);
    end
    start = 1'b0;
    abort = 1'b0;

    // size=1, layer_count=1
    @(negedge clk);
    d_start = 1'b1;
    @(posedge clk);
    #1;
    d_start = 1'b0;
    chk("deg_cost", pk(d_busy, d_done, d_upd, d_cost, d_bc, d_layer, d_row),
        ev(1, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    chk("deg_dense", pk(d_busy, d_done, d_upd, d_cost, d_bc, d_layer, d_row),
        ev(1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("deg_done", pk(d_busy, d_done, d_upd, d_cost, d_bc, d_layer, d_row),
        DNE);
    @(posedge clk);
    #1;
    chk("deg_idle", pk(d_busy, d_done, d_upd, d_cost, d_bc, d_layer, d_row),
        IDL);

    // step_ready toggling every cycle against the expected step order
    for (int r = 0; r < 3; r++) begin
      sl[r] = 1; srw[r] = r; sc[r] = 1'b1;
    end
    for (int l = 1; l >= 0; l--) begin
      for (int r = 0; r < 3; r++) begin
        sl[3 + (1 - l) * 3 + r]  = l;
        srw[3 + (1 - l) * 3 + r] = r;
        sc[3 + (1 - l) * 3 + r]  = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b1;
    step_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    idx = 0;
    for (int k = 0; k < 60 && idx < 9; k++) begin
      @(negedge clk);
      chk($sformatf("tog%0d", k),
          pk(busy, done, is_update, is_cost_layer, backprop_cost,
             w_layer_index, w_row_index),
          ev(1, 0, sc[idx], sl[idx], srw[idx]));
      step_ready = ~step_ready;
      if (step_ready) idx++;
    end
    nchk++;
    if (idx == 9) npass++;
    else $display("FAIL tog_budget steps=%0d need=9", idx);
    @(negedge clk);
    chk("tog_done", pk(busy, done, is_update, is_cost_layer, backprop_cost,
                       w_layer_index, w_row_index), DNE);
    @(negedge clk);
    chk("tog_idle", pk(busy, done, is_update, is_cost_layer, backprop_cost,
                       w_layer_index, w_row_index), IDL);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/backprop_sequencer.md
# backprop_sequencer

Generates the per-step control stream that drives `backprop_stack_controller` during a backpropagation pass: `is_update`, `w_layer_index`, `w_row_index`, `is_cost_layer` and `backprop_cost`. On `start` it walks a cost phase and then every dense layer from the output side down to layer 0, one weight row per step. It holds each step until the downstream datapath signals `step_ready`. It sits between the training top-level FSM and `backprop_stack_controller`.

## Interface
Parameters:
- `size`, 3, number of weight rows per layer. This matches the controller's `size`. Must be ≥ 1.
- `layer_count`, 3, number of dense layers. Must be ≥ 1 and < 2^32.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`  in  1  begin a pass. Sampled only in IDLE.
- `abort`  in  1  terminate the pass and return to IDLE.
- `step_ready`  in  1  downstream has consumed the current step.
- `busy`  out  1  high in COST and DENSE.
- `done`  out  1  one-cycle pulse after the last step is consumed.
- `is_update`  out  1  a valid step is presented.
- `w_layer_index`  out  32  layer of the current step.
- `w_row_index`  out  32  row of the current step, 0..size-1.
- `is_cost_layer`  out  1  current step belongs to the cost phase.
- `backprop_cost`  out  1  current step propagates the cost gradient.

## Operation
All outputs are registered. The FSM has four states: IDLE, COST, DENSE, DONE.

- **IDLE.** All step outputs are 0. When `start`=1 the FSM moves to COST with layer=`layer_count`-1 and row=0.
- **COST.** Outputs are `is_update`=1, `is_cost_layer`=1, `backprop_cost`=1 and `w_layer_index`=`layer_count`-1.
  - Row advances by 1 on each cycle where `step_ready`=1.
  - When row=`size`-1 and `step_ready`=1, the FSM moves to DENSE with layer=`layer_count`-1 and row=0.
- **DENSE.** Outputs are `is_update`=1, `is_cost_layer`=0, `backprop_cost`=0.
  - Row advances on each cycle where `step_ready`=1.
  - When row=`size`-1 and `step_ready`=1:
    - if layer>0: layer decrements and row resets to 0;
    - if layer=0: the FSM moves to DONE.
- **DONE.** `done`=1 and step outputs are 0 for exactly one cycle, then the FSM returns to IDLE.

Rules that apply in every state:
- **Held step.** When `step_ready`=0, every step output holds its value.
- **Zeroing.** Step outputs are forced to 0 whenever `is_update`=0. This makes the downstream `w_layer_index_out` / `w_row_index_out` zero.
- **Abort.** `abort`=1 in COST or DENSE moves the FSM to IDLE on the next edge, with all outputs 0 and no `done` pulse. `abort` outranks `step_ready`. `abort` in IDLE or DONE has no effect.
- **Start while active.** `start` is ignored in COST, DENSE and DONE.
- **Start and abort together in IDLE.** `start` wins.
- **Counter widths.** Row and layer counters are 32-bit. Comparisons use `size`-1 and 0. There is no wrap-around: the layer counter never decrements below 0.
- **Degenerate sizes.**
  - `size`=1: each phase and each layer takes one step.
  - `layer_count`=1: the cost phase and the single dense layer both use layer 0.

## Timing
- **Reset.** With `reset_n`=0 at an edge, the FSM enters IDLE. `busy`, `done`, `is_update`, `is_cost_layer` and `backprop_cost` become 0, and `w_layer_index` and `w_row_index` become 0. This holds mid-pass as well; the pass is not resumed.
- **Start latency.** `start` sampled at edge N gives the first step (`is_update`=1) visible after edge N, i.e. during cycle N+1.
- **Step handshake.** A step is consumed on an edge where `is_update`=1 and `step_ready`=1. The next step is visible in the following cycle. With `step_ready` tied high, one step completes per cycle.
- **Pass length.** A pass has `size`×(`layer_count`+1) steps. With `step_ready` high throughout, `done` is high in cycle N+1+`size`×(`layer_count`+1).
- **`busy`.** `busy` is high exactly when `is_update`=1.

## Test plan
1. **Full pass, no stalls.** Settings: `size`=3, `layer_count`=2, `step_ready`=1, `start` pulse at cycle 0.
   - Cycles 1–3: (L1, R0..2) with `is_cost_layer`=`backprop_cost`=1.
   - Cycles 4–6: (L1, R0..2) with both flags 0.
   - Cycles 7–9: (L0, R0..2).
   - `done`=1 in cycle 10; IDLE with all outputs 0 in cycle 11.
2. **Stall.** In scenario 1, drop `step_ready` during cycles 5–7.
   - The step (L1, R1, dense) is held for 4 cycles.
   - `done` moves to cycle 13.
   - The step count remains 9.
3. **Abort.** Assert `abort` while in step (L1, R2, cost) with `step_ready`=1.
   - Next cycle: all outputs 0, `busy`=0, and `done` never pulses.
   - A later `start` restarts at (L1, R0, cost).
4. **Reset mid-pass.** Drive `reset_n`=0 for 1 cycle during the dense phase.
   - All outputs are 0 the next cycle.
   - `start` pulses during the pass, including in DONE, are ignored.
5. **Degenerate.** Settings: `size`=1, `layer_count`=1, `step_ready`=1.
   - Steps: (L0, R0, cost), then (L0, R0, dense).
   - `done` in cycle 3.
6. **Coverage.** Cover `step_ready` toggling every cycle.
   - Each step is presented for exactly the number of cycles until the first `step_ready`=1.
   - Rows never skip or repeat.
